// File: rtl/pwm_edge_sequencer.sv
// pwm_edge_sequencer: single-channel PWM that orders two shadowed compare values into set/clear edges
// and applies them at period boundaries.
module pwm_find_smaller #(
  parameter int Resolution = 16
) (
  input  logic [Resolution-1:0] a,
  input  logic [Resolution-1:0] b,
  output logic [Resolution-1:0] lo,
  output logic [Resolution-1:0] hi
);
  assign lo = (a < b) ? a : b;
  assign hi = (a < b) ? b : a;
endmodule

module pwm_edge_sequencer #(
  parameter int Resolution = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [Resolution-1:0] cfg_period,
  input  logic [Resolution-1:0] cfg_cmp_a,
  input  logic [Resolution-1:0] cfg_cmp_b,
  output logic                  pwm_out,
  output logic [Resolution-1:0] counter_value,
  output logic                  period_start,
  output logic                  update_pending
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state_q, state_d;
  logic [Resolution-1:0] sh_per_q, sh_a_q, sh_b_q, sh_lo, sh_hi;
  logic [Resolution-1:0] per_q, per_d, lo_q, lo_d, hi_q, hi_d, cnt_q, cnt_d;
  logic pend_q, pend_d, pwm_q, pwm_d, ps_q, ps_d, xfer, apply, wrap;
  pwm_find_smaller #(.Resolution(Resolution)) u_order (
    .a (sh_a_q),
    .b (sh_b_q),
    .lo(sh_lo),
    .hi(sh_hi)
  );
  assign xfer = cfg_valid && !pend_q;
  assign wrap = cnt_q == per_q;
  // Outputs are computed from the next count and next edges so pwm_out and counter_value always agree.
  always_comb begin
    state_d = state_q;
    apply   = 1'b0;
    cnt_d   = '0;
    case (state_q)
      IDLE: state_d = enable ? LOAD : IDLE;
      LOAD: begin
        apply   = 1'b1;
        state_d = enable ? RUN : IDLE;
      end
      RUN: begin
        state_d = enable ? RUN : IDLE;
        apply   = enable && wrap && pend_q;
        cnt_d   = (enable && !wrap) ? cnt_q + Resolution'(1) : '0;
      end
      default: state_d = IDLE;
    endcase
    per_d  = apply ? sh_per_q : per_q;
    lo_d   = apply ? sh_lo : lo_q;
    hi_d   = apply ? sh_hi : hi_q;
    pend_d = xfer || (pend_q && !apply);
    pwm_d  = (state_d == RUN) && (lo_d <= cnt_d) && (cnt_d < hi_d);
    ps_d   = (state_d == RUN) && (cnt_d == '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sh_per_q <= '0;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      per_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      pwm_q    <= 1'b0;
      ps_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pwm_q   <= pwm_d;
      ps_q    <= ps_d;
      if (xfer) begin
        sh_per_q <= cfg_period;
        sh_a_q   <= cfg_cmp_a;
        sh_b_q   <= cfg_cmp_b;
      end
    end
  end
  assign cfg_ready      = !pend_q;
  assign update_pending = pend_q;
  assign pwm_out        = pwm_q;
  assign counter_value  = cnt_q;
  assign period_start   = ps_q;
endmodule

// File: tb/tb_pwm_edge_sequencer.sv
// tb_pwm_edge_sequencer: directed stimulus with a cycle-level behavioural model and literal spot checks.
module tb_pwm_edge_sequencer;
  localparam int R = 16;
  logic clk = 0, rst_n = 0, enable = 0, cfg_valid = 0;
  logic [R-1:0] cfg_period = '0, cfg_cmp_a = '0, cfg_cmp_b = '0;
  logic cfg_ready, pwm_out, period_start, update_pending;
  logic [R-1:0] counter_value;
  int n_cmp = 0, n_bad = 0;

  pwm_edge_sequencer #(.Resolution(R)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_cmp_a(cfg_cmp_a), .cfg_cmp_b(cfg_cmp_b), .pwm_out(pwm_out),
    .counter_value(counter_value), .period_start(period_start), .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 loading, 2 running; outputs are a pure function of the model state.
  int m_mode = 0;
  logic [R-1:0] m_cnt = '0, m_per = '0, m_lo = '0, m_hi = '0, s_per = '0, s_a = '0, s_b = '0;
  logic m_pend = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_cnt = '0; m_per = '0; m_lo = '0; m_hi = '0;
      s_per = '0; s_a = '0; s_b = '0; m_pend = 0;
    end else begin
      automatic bit xfer = cfg_valid && !m_pend;
      automatic bit app = 0;
      if (m_mode == 0) begin
        m_mode = enable ? 1 : 0;
      end else if (m_mode == 1) begin
        app = 1; m_mode = enable ? 2 : 0; m_cnt = '0;
      end else if (!enable) begin
        m_mode = 0; m_cnt = '0;
      end else if (m_cnt == m_per) begin
        m_cnt = '0; app = m_pend;
      end else begin
        m_cnt = m_cnt + 1'b1;
      end
      if (app) begin
        m_per = s_per;
        m_lo = (s_a < s_b) ? s_a : s_b;
        m_hi = (s_a < s_b) ? s_b : s_a;
        m_pend = 0;
      end
      if (xfer) begin
        s_per = cfg_period; s_a = cfg_cmp_a; s_b = cfg_cmp_b; m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    check("m_pwm", pwm_out, (m_mode == 2) && (m_lo <= m_cnt) && (m_cnt < m_hi));
    check("m_cnt", counter_value, m_cnt);
    check("m_ps", period_start, (m_mode == 2) && (m_cnt == 0));
    check("m_pend", update_pending, m_pend);
    check("m_rdy", cfg_ready, !m_pend);
  end

  // Called right after a falling edge; holds the request until it has been accepted.
  task automatic cfg(input int p, input int a, input int b);
    int k = 0;
    cfg_valid = 1; cfg_period = R'(p); cfg_cmp_a = R'(a); cfg_cmp_b = R'(b);
    while (!cfg_ready && k < 100) begin @(negedge clk); k++; end
    check("cfg_accept", cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 0;
  endtask

  task automatic wait_cnt(input int c);
    int k = 0;
    while (counter_value != R'(c) && k < 100) begin @(negedge clk); k++; end
    check("wait_cnt", counter_value, c);
  endtask

  task automatic wait_applied();
    int k = 0;
    while (update_pending && k < 100) begin @(negedge clk); k++; end
    check("wait_apply", update_pending, 0);
  endtask

  logic [9:0] pat;
  initial begin
    repeat (3) @(negedge clk);
    check("rst_rdy", cfg_ready, 1);
    check("rst_pwm", pwm_out, 0);
    rst_n = 1;
    @(negedge clk);
    cfg(9, 7, 2);
    enable = 1;
    @(negedge clk);
    @(negedge clk);
    check("first_cnt", counter_value, 0);
    check("first_ps", period_start, 1);
    for (int i = 0; i < 10; i++) begin pat[i] = pwm_out; @(negedge clk); end
    check("wave_72", pat, 10'b0001111100);
    cfg(9, 2, 7);
    wait_applied();
    wait_cnt(0);
    for (int i = 0; i < 10; i++) begin pat[i] = pwm_out; @(negedge clk); end
    check("wave_27", pat, 10'b0001111100);
    wait_cnt(4);
    cfg_valid = 1; cfg_period = 9; cfg_cmp_a = 5; cfg_cmp_b = 5;
    @(negedge clk);
    cfg_valid = 0;
    check("rdy_at5", cfg_ready, 0);
    check("cnt_5", counter_value, 5);
    check("old_wave_5", pwm_out, 1);
    wait_cnt(0);
    check("rdy_after", cfg_ready, 1);
    for (int i = 0; i < 10; i++) begin pat[i] = pwm_out; @(negedge clk); end
    check("wave_eq", pat, 10'b0);
    cfg(9, 7, 2);
    cfg(9, 3, 8);
    wait_applied();
    wait_cnt(9);
    cfg_valid = 1; cfg_period = 9; cfg_cmp_a = 1; cfg_cmp_b = 5;
    @(negedge clk);
    cfg_valid = 0;
    check("wrap_xfer_pend", update_pending, 1);
    check("wrap_xfer_pwm", pwm_out, 0);
    wait_cnt(9);
    @(negedge clk);
    check("wrap2_pend", update_pending, 0);
    @(negedge clk);
    check("wrap2_pwm", pwm_out, 1);
    cfg(0, 0, 1);
    wait_applied();
    for (int i = 0; i < 3; i++) begin
      check("p0_pwm", pwm_out, 1);
      check("p0_ps", period_start, 1);
      check("p0_cnt", counter_value, 0);
      @(negedge clk);
    end
    cfg(3, 1, 10);
    wait_applied();
    wait_cnt(0);
    pat = '0;
    for (int i = 0; i < 4; i++) begin pat[i] = pwm_out; @(negedge clk); end
    check("wave_hi_gt_per", pat, 10'b1110);
    cfg(9, 2, 7);
    wait_applied();
    cfg(9, 3, 4);
    wait_cnt(6);
    enable = 0;
    @(negedge clk);
    check("dis_cnt", counter_value, 0);
    check("dis_pwm", pwm_out, 0);
    check("dis_pend", update_pending, 1);
    enable = 1;
    repeat (5) @(negedge clk);
    cfg_valid = 1; cfg_period = 5; cfg_cmp_a = 0; cfg_cmp_b = 9;
    @(negedge clk);
    cfg_valid = 0;
    #2 rst_n = 0;
    #1;
    check("arst_pend", update_pending, 0);
    check("arst_rdy", cfg_ready, 1);
    check("arst_cnt", counter_value, 0);
    check("arst_pwm", pwm_out, 0);
    check("arst_ps", period_start, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (6) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pwm_edge_sequencer.md
# pwm_edge_sequencer

Single-channel PWM controller that sequences the shared `pwm_find_smaller` ordering datapath. It keeps a free-running period counter and holds two programmable compare values in shadow registers. At each period boundary it applies the shadow values and orders them into a set edge and a clear edge. The block sits between the register interface (configuration handshake) and the PWM output pin, so software can write the two compare values in any order.

## Interface
- `Resolution`, 16, width of counter, period and compare values.

- `clk` in 1: system clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run request; level-sensitive.
- `cfg_valid` in 1: configuration word valid.
- `cfg_ready` out 1: shadow register free; transfer when `cfg_valid && cfg_ready`.
- `cfg_period` in Resolution: last count of the period (period length = `cfg_period`+1 cycles).
- `cfg_cmp_a` in Resolution: compare value A.
- `cfg_cmp_b` in Resolution: compare value B.
- `pwm_out` out 1: registered PWM output.
- `counter_value` out Resolution: registered current count.
- `period_start` out 1: one-cycle pulse while `counter_value`==0 in RUN.
- `update_pending` out 1: shadow holds values not yet applied.

## Operation
- The block instantiates one `pwm_find_smaller` on the shadow A/B. Its outputs `lo` = min(A,B) and `hi` = max(A,B) are captured into the active registers whenever shadow values are applied.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: counter=0, `pwm_out`=0, `period_start`=0. If `enable`=1, go to LOAD.
  - LOAD (1 cycle): copy shadow period/lo/hi into the active registers and clear `update_pending`. Go to RUN with counter=0. If `enable`=0 in LOAD, go to IDLE; the apply still happens.
  - RUN: counter increments by 1 per cycle. At count == active period, the next count is 0 (wrap). On the wrap cycle, if `update_pending`=1, the shadow is applied so the new values govern the count-0 cycle. If `enable`=0, go to IDLE next cycle, with counter and `pwm_out` forced to 0. `update_pending` and the shadow are retained.
- Output rule in RUN: `pwm_out`=1 iff lo <= `counter_value` < hi, evaluated on the same count shown on `counter_value`. Both outputs are registered and always consistent.
- Configuration handshake:
  - `cfg_ready` = !`update_pending`.
  - A transfer writes all three shadow fields and sets `update_pending` the next cycle.
  - `cfg_valid` without `cfg_ready` is held by the master; nothing is captured.
  - The shadow is never written while pending, so an apply and a capture never collide.
- Boundary conditions:
  - A==B → lo==hi → `pwm_out` constantly 0.
  - lo=0 and hi > active period → `pwm_out` constantly 1.
  - hi > period → output stays high from lo through the wrap cycle and falls at count 0 (unless lo=0).
  - Period=0 → counter stays 0, `period_start`=1 every RUN cycle, `pwm_out` = (lo==0 && hi>0).
  - Arithmetic is unsigned, Resolution bits. The counter never exceeds the active period, so there is no overflow.
- Reset values:
  - State IDLE, counter 0, `pwm_out` 0, `period_start` 0.
  - `cfg_ready` 1, `update_pending` 0.
  - Shadow and active period/lo/hi all 0.
- Reset asserted mid-operation returns immediately to the reset values, and pending configuration is discarded.

## Timing
- `enable` sampled 1 in IDLE at cycle t: state LOAD at t+1. At t+2 the state is RUN with `counter_value`=0, `period_start`=1 and `pwm_out`=(lo==0 && hi>0).
- A transfer at cycle t gives `update_pending`=1 and `cfg_ready`=0 from t+1.
- An apply on a wrap edge gives `update_pending`=0 and `cfg_ready`=1 on the count-0 cycle.
- A transfer accepted on the wrap cycle itself is applied at the following wrap, not the current one.
- `enable` sampled 0 in RUN at cycle t: at t+1 the state is IDLE, `pwm_out`=0 and `counter_value`=0.
- Latency from counter value to `pwm_out`: 0 cycles. Both are registered from the same next-state logic.

## Test plan
- Reset, then cfg period=9, A=7, B=2, then `enable`=1 → LOAD. The first RUN cycle shows count 0 with `period_start`=1. `pwm_out`=1 for counts 2..6 and 0 otherwise, repeating every 10 cycles.
- Swapped order: A=2, B=7 with the same period → waveform identical to the previous case cycle-for-cycle.
- While running period=9/2/7, transfer A=B=5 at count 4 → `cfg_ready` is 0 from count 5. Old waveform continues to wrap. From the next count 0, `pwm_out` is constantly 0 and `cfg_ready`=1.
- Hold `cfg_valid` while pending → no capture until `cfg_ready`=1. Transfer exactly on the count-9 wrap cycle → applied at the second wrap, not the first.
- Edge cases: period=0 with A=0, B=1 → `pwm_out`=1 and `period_start`=1 every cycle. Period=3, A=1, B=10 → `pwm_out` pattern 0,1,1,1.
- Drop `enable` at count 6 → IDLE next cycle with outputs 0 and `update_pending` kept. Assert `rst_n`=0 mid-RUN → all outputs take reset values asynchronously and the pending update is cleared.
